sprite_rom_arbiter: RTL
=======================

# sprite_rom_arbiter

Shares the single synchronous sprite ROM between several pixel-pipeline requesters: background tile fetch, player sprite and enemy/projectile sprites. Requester 0, the background scanline fetch, is real-time and has strict priority. Requesters 1..NUM_REQ-1 share the remaining slots round-robin. A starvation guard forces a round-robin slot after a bounded run of requester-0 wins. One grant per cycle; read data is returned with a one-hot valid tag after the fixed ROM latency.

## Interface
- NUM_REQ, 4: number of requesters; legal range 2..8.
- ADDR_W, 6: sprite ROM address width.
- DATA_W, 32: sprite ROM row width (one 32-pixel tile row).
- ROM_LAT, 1: ROM read latency in cycles, from the address-sampling edge to data on rom_data; legal range 1..3.
- MAX_WAIT, 8: consecutive requester-0 grants tolerated while a round-robin request is pending; legal range 1..255.

Ports:
- Clk  in  1  system clock; all state on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  request per requester; held high with address stable until granted.
- addr_in  in  NUM_REQ*ADDR_W  packed addresses; requester i at bits [i*ADDR_W +: ADDR_W].
- gnt  out  NUM_REQ  one-hot (or zero) grant for the current cycle; combinational.
- rom_addr  out  ADDR_W  address to the ROM; combinational; equals the granted requester's address, else 0.
- rom_data  in  DATA_W  ROM read data.
- rdata  out  DATA_W  rom_data passed through; meaningful only while some rvalid bit is high.
- rvalid  out  NUM_REQ  one-hot tag marking which requester owns rdata this cycle.

## Operation
- State:
  - rr_ptr (range 1..NUM_REQ-1; reset value 1).
  - starve_cnt (width clog2(MAX_WAIT+1); reset value 0).
  - tag pipeline: ROM_LAT stages of NUM_REQ bits; all stages reset to 0.
- Define rr_pend = |req[NUM_REQ-1:1].
- Arbitration, evaluated combinationally each cycle:
  - Forced mode: when starve_cnt == MAX_WAIT and rr_pend, the round-robin winner is granted even if req[0] is high.
  - Otherwise, if req[0] is high, requester 0 is granted.
  - Otherwise, the round-robin winner is granted if rr_pend.
  - Otherwise, gnt = 0.
- Round-robin winner: the first k with req[k] high, searching k = rr_ptr, rr_ptr+1, ..., NUM_REQ-1, then 1, ..., rr_ptr-1. Requester 0 is never part of this search.
- Updates on each rising edge:
  - When a round-robin grant is issued to k: rr_ptr <= k+1, wrapping from NUM_REQ to 1. Otherwise rr_ptr holds.
  - When requester 0 is granted and rr_pend: starve_cnt <= starve_cnt+1, saturating at MAX_WAIT.
  - When a round-robin grant is issued, or when rr_pend is low: starve_cnt <= 0.
  - Tag pipeline: stage 0 <= gnt, and stage s <= stage s-1. rvalid is the last stage.
- A requester drops req in the cycle after its gnt, or keeps it high to issue another request. A new address may be presented in the same cycle as that next request.
- Address sampling at the grant edge: rom_addr is sampled by the ROM on the edge that ends the grant cycle.
- In-order return: each grant produces exactly one rvalid pulse; no reordering.

## Timing
- Grant latency: 0 cycles. gnt is asserted in the same cycle req is seen, if the requester wins.
- Read latency: rvalid[i] is high exactly ROM_LAT cycles after the gnt[i] cycle. rdata then equals ROM[address granted].
- Throughput: 1 grant per cycle sustained. Back-to-back returns can carry different tags in consecutive cycles.
- Reset values, while Reset_n is low:
  - gnt = 0, rom_addr = 0, rvalid = 0 (all forced, regardless of req).
  - rr_ptr = 1, starve_cnt = 0.
- Reset mid-operation: in-flight tags are cleared immediately and asynchronously. No rvalid is produced for grants issued before reset. Operation resumes on the first edge after Reset_n rises.
- Simultaneous events: when req[0] and one or more round-robin requests are present with starve_cnt < MAX_WAIT, requester 0 wins and starve_cnt increments.
- MAX_WAIT = 1: round-robin and requester 0 strictly alternate under full contention.
- rr_ptr wrap: after a grant to NUM_REQ-1, the search starts at 1.

## Test plan
- Single request: req = 4'b0001, addr0 = 6'd5, ROM_LAT = 1 -> gnt = 0001 in the same cycle; rom_addr = 5; next cycle rvalid = 0001 and rdata = ROM[5].
- Round-robin rotation: req[3:1] held high, req[0] low, for 6 cycles -> grant order 1, 2, 3, 1, 2, 3; starve_cnt stays 0.
- Starvation guard: MAX_WAIT = 4, req[0] and req[1] held continuously -> grant pattern 0, 0, 0, 0, 1, 0, 0, 0, 0, 1; starve_cnt returns to 0 after each grant to 1.
- Pipelined returns: ROM_LAT = 2 with grants 0, 2, 1 in consecutive cycles -> rvalid = 0001, 0100, 0010 in cycles t+2, t+3, t+4, each with the matching ROM row.
- Reset mid-flight: ROM_LAT = 3, Reset_n pulsed low one cycle after a grant -> rvalid stays 0; rr_ptr = 1 and starve_cnt = 0 afterwards; the first post-reset request is handled normally.
- Idle: req = 0 for 10 cycles -> gnt = 0, rom_addr = 0, rvalid = 0; rr_ptr unchanged.

Source files
------------

// File: rtl/sprite_rom_arbiter.sv
// Sprite ROM arbiter: requester 0 strict priority, 1..NUM_REQ-1 round-robin, starvation guard.
// Grant is combinational (0 cycles); rvalid tag follows ROM_LAT cycles later; losers simply hold req.
module sprite_rom_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 32,
  parameter int ROM_LAT  = 1,
  parameter int MAX_WAIT = 8
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] addr_in,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_data,
  output logic [DATA_W-1:0]         rdata,
  output logic [NUM_REQ-1:0]        rvalid
);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_WAIT);
  localparam logic [PTR_W-1:0] PTR_FIRST = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]   starve_cnt;
  logic [NUM_REQ-1:0] tag_q [ROM_LAT];

  logic               rr_pend;
  logic               forced;
  logic               rr_gnt;
  logic               zero_gnt;
  logic [PTR_W-1:0]   rr_win;
  int                 rr_idx;

  assign rr_pend = |req[NUM_REQ-1:1];
  assign forced  = (starve_cnt == CNT_MAX) && rr_pend;

  // Scan from the far end back toward rr_ptr so the last hit is the first in search order.
  always_comb begin
    rr_win = PTR_FIRST;
    rr_idx = 0;
    for (int off = NUM_REQ - 2; off >= 0; off--) begin
      rr_idx = ((int'(rr_ptr) - 1 + off) % (NUM_REQ - 1)) + 1;
      if (req[rr_idx]) rr_win = PTR_W'(rr_idx);
    end
  end

  // Reset gates the combinational grant so nothing reaches the ROM while Reset_n is low.
  assign rr_gnt   = Reset_n && rr_pend && (forced || !req[0]);
  assign zero_gnt = Reset_n && req[0] && !forced;

  always_comb begin
    gnt = '0;
    if (zero_gnt)    gnt[0]      = 1'b1;
    else if (rr_gnt) gnt[rr_win] = 1'b1;
  end

  always_comb begin
    rom_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) rom_addr = addr_in[i*ADDR_W +: ADDR_W];
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rr_ptr     <= PTR_FIRST;
      starve_cnt <= '0;
    end else begin
      if (rr_gnt) rr_ptr <= (rr_win == PTR_LAST) ? PTR_FIRST : rr_win + PTR_FIRST;
      if (rr_gnt || !rr_pend) starve_cnt <= '0;
      else if (zero_gnt && starve_cnt != CNT_MAX) starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  // Tag line tracks the ROM pipeline so each grant yields one rvalid pulse in order.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int s = 0; s < ROM_LAT; s++) tag_q[s] <= '0;
    end else begin
      tag_q[0] <= gnt;
      for (int s = 1; s < ROM_LAT; s++) tag_q[s] <= tag_q[s-1];
    end
  end

  assign rvalid = tag_q[ROM_LAT-1];
  assign rdata  = rom_data;

endmodule
